// File: rtl/reg_dump_pkg.sv
// Shared types and helpers for the register-dump UART transmitter.
package reg_dump_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, FIN} state_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] data;
  } tx_req_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // The frame sequencer preloads during the second-to-last stop cycle, so a bit
  // must last at least two clocks; slower ratios are clamped up to two.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    int cpb;
    cpb = clk_hz / baud;
    return (cpb < 2) ? 2 : cpb;
  endfunction

  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 byte serializer: valid/ready byte in, start + 8 data (LSB first) + stop out.
module uart_tx_8n1
  import reg_dump_pkg::*;
#(
  parameter int CPB = 16
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iValid,
  output logic       oReady,
  input  logic [7:0] iData,
  output logic       oTxd,
  output logic       oStop,
  output logic       oNearEnd
);

  localparam int CW = $clog2(CPB);

  state_t          st_q, st_d;
  logic [CW-1:0]   baud_q;
  logic [2:0]      bit_q;
  logic [7:0]      sh_q;
  logic            bit_end;

  assign bit_end = (baud_q == CW'(CPB - 1));

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) st_q <= IDLE;
    else         st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    if (iValid) st_d = START;
      START:   if (bit_end) st_d = DATA;
      DATA:    if (bit_end && bit_q == 3'd7) st_d = STOP;
      STOP:    if (bit_end) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      baud_q <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
    end else if (st_q == IDLE) begin
      baud_q <= '0;
      bit_q  <= '0;
      if (iValid) sh_q <= iData;
    end else begin
      baud_q <= bit_end ? '0 : baud_q + CW'(1);
      if (bit_end && st_q == DATA) begin
        sh_q  <= {1'b0, sh_q[7:1]};
        bit_q <= bit_q + 3'd1;
      end
    end
  end

  // oNearEnd flags the second-to-last stop cycle so the next byte can be
  // loaded with exactly one idle-high clock between frames.
  always_comb begin
    oTxd     = 1'b1;
    oReady   = 1'b0;
    oStop    = 1'b0;
    oNearEnd = 1'b0;
    case (st_q)
      IDLE:  oReady = 1'b1;
      START: oTxd   = 1'b0;
      DATA:  oTxd   = sh_q[0];
      STOP: begin
        oStop    = 1'b1;
        oNearEnd = (baud_q == CW'(CPB - 2));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_dump_uart_tx.sv
// Walks register addresses 0..NUM_REGS-1 and sends each byte as an 8N1 frame.
// Define REG_DUMP_ASCII_EN to send two uppercase hex chars per register plus CR/LF.
module reg_dump_uart_tx
  import reg_dump_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int BAUD     = 115200,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 8
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iStart,
  output logic [ADDR_W-1:0] oRa,
  input  logic [DATA_W-1:0] iRd,
  output logic              oTxd,
  output logic              oBusy,
  output logic              oDone
);

  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
`ifdef REG_DUMP_ASCII_EN
  localparam int FRAMES = 2 * NUM_REGS + 2;
`else
  localparam int FRAMES = NUM_REGS;
`endif
  localparam int FW = $clog2(FRAMES + 1);

  state_t            st_q, st_d;
  logic [FW-1:0]     frm_q, frm_nxt;
  logic [ADDR_W-1:0] ra_q, ra_nxt;
  logic [7:0]        tx_q, ld_char;
  tx_req_t           req;
  logic              tx_ready, tx_stop, tx_near;
  logic              more, adv;

  assign more    = (frm_q != FW'(FRAMES - 1));
  assign adv     = tx_near && more && (st_q == DATA || st_q == STOP);
  assign frm_nxt = frm_q + FW'(1);

`ifdef REG_DUMP_ASCII_EN
  logic [7:0] byte_q;

  // Address only moves on the high-nibble char; it parks on the last register during CR/LF.
  assign ra_nxt = (frm_nxt < FW'(2 * NUM_REGS)) ? ADDR_W'(frm_nxt >> 1) : ra_q;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) byte_q <= '0;
    else if (st_q == LOAD && !frm_q[0] && frm_q < FW'(2 * NUM_REGS)) byte_q <= iRd;
  end

  always_comb begin
    if (frm_q == FW'(FRAMES - 1))      ld_char = ASCII_LF;
    else if (frm_q == FW'(FRAMES - 2)) ld_char = ASCII_CR;
    else if (frm_q[0])                 ld_char = nib2ascii(byte_q[3:0]);
    else                               ld_char = nib2ascii(iRd[7:4]);
  end
`else
  assign ra_nxt = ADDR_W'(frm_nxt);

  always_comb ld_char = iRd;
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) st_q <= IDLE;
    else         st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:  if (iStart) st_d = LOAD;
      LOAD:  st_d = START;
      START: if (tx_ready) st_d = DATA;
      DATA: begin
        if (adv)          st_d = LOAD;
        else if (tx_stop) st_d = STOP;
      end
      STOP: begin
        if (adv)                    st_d = LOAD;
        else if (!more && tx_ready) st_d = FIN;
      end
      FIN:     st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      frm_q <= '0;
      ra_q  <= '0;
      tx_q  <= '0;
    end else begin
      if (st_q == IDLE && iStart) begin
        frm_q <= '0;
        ra_q  <= '0;
      end
      if (adv) begin
        frm_q <= frm_nxt;
        ra_q  <= ra_nxt;
      end
      if (st_d == FIN)  ra_q <= '0;
      if (st_q == LOAD) tx_q <= ld_char;
    end
  end

  always_comb begin
    oBusy    = 1'b1;
    oDone    = 1'b0;
    req.vld  = (st_q == START);
    req.data = tx_q;
    case (st_q)
      IDLE: oBusy = 1'b0;
      FIN: begin
        oBusy = 1'b0;
        oDone = 1'b1;
      end
      default: ;
    endcase
  end

  assign oRa = ra_q;

  uart_tx_8n1 #(.CPB(CPB)) u_tx (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .iValid   (req.vld),
    .oReady   (tx_ready),
    .iData    (req.data),
    .oTxd     (oTxd),
    .oStop    (tx_stop),
    .oNearEnd (tx_near)
  );

endmodule

// File: tb/tb_reg_dump_uart_tx.sv
// Bench for reg_dump_uart_tx at 16 clocks/bit with an 8-register model on oRa/iRd.
module tb_reg_dump_uart_tx;

  localparam int N   = 8;
  localparam int CPB = 16;
  localparam int FT  = 10 * CPB + 1;
`ifdef REG_DUMP_ASCII_EN
  localparam int NFR = 2 * N + 2;
`else
  localparam int NFR = N;
`endif

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b1;
  logic       iStart = 1'b0;
  logic [2:0] oRa;
  logic [7:0] iRd;
  logic       oTxd, oBusy, oDone;

  logic [7:0] regs [N];
  logic [7:0] exp_q [$];
  int nvec = 0;
  int nerr = 0;

  always #5 iCLK = ~iCLK;
  assign iRd = regs[oRa];

  reg_dump_uart_tx #(
    .CLK_HZ(16), .BAUD(1), .NUM_REGS(N), .ADDR_W(3), .DATA_W(8)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iStart(iStart), .oRa(oRa),
    .iRd(iRd), .oTxd(oTxd), .oBusy(oBusy), .oDone(oDone)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected byte stream for a dump, from a snapshot of the register values.
  function automatic void build_exp(input logic [7:0] snap [N]);
    string hx;
    hx = "0123456789ABCDEF";
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
`ifdef REG_DUMP_ASCII_EN
      exp_q.push_back(hx[snap[i] / 16]);
      exp_q.push_back(hx[snap[i] % 16]);
`else
      exp_q.push_back(snap[i]);
`endif
    end
`ifdef REG_DUMP_ASCII_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endfunction

  // One dump from acceptance; samples the line mid-bit and checks each frame,
  // each inter-frame gap, oBusy/oDone timing and the address range.
  task automatic run_dump(input int pulse_at, input int wr_at, input logic [7:0] w0,
                          input logic [7:0] w3, input int abort_at);
    int done_t = -1;
    int done_n = 0;
    int max_ra = 0;
    int p, f, r;
    logic [9:0] word = '0;
    @(posedge iCLK); #1 iStart = 1'b1;
    @(posedge iCLK); #1 iStart = 1'b0;
    for (int t = 0; t < NFR * FT + 6; t++) begin
      @(negedge iCLK);
      if (t == 0) begin
        chk("busy_after_accept", oBusy, 1'b1);
        chk("ra_after_accept", oRa, 3'd0);
      end
      if (t < 2) chk("line_before_start", oTxd, 1'b1);
      p = t - 2;
      if (p >= 0 && p < NFR * FT) begin
        f = p / FT;
        r = p % FT;
        if (r < 10 * CPB && r % CPB == CPB / 2) begin
          word[r / CPB] = oTxd;
          if (r / CPB == 9) chk($sformatf("frame%0d", f), word, {1'b1, exp_q[f], 1'b0});
        end
        if (r == 10 * CPB) chk($sformatf("gap%0d", f), oTxd, 1'b1);
      end
      if (t == NFR * FT + 1) chk("busy_before_done", oBusy, 1'b1);
      if (t == NFR * FT + 2) chk("busy_at_done", oBusy, 1'b0);
      if (oDone) begin
        done_n++;
        if (done_t < 0) done_t = t;
      end
      if (int'(oRa) > max_ra) max_ra = int'(oRa);
      iStart = (t == pulse_at);
      if (t == wr_at) begin
        regs[0] = w0;
        regs[3] = w3;
      end
      if (t == abort_at) begin
        iRST_N = 1'b0;
        #1;
        chk("abort_txd", oTxd, 1'b1);
        chk("abort_busy", oBusy, 1'b0);
        chk("abort_ra", oRa, 3'd0);
        #2 iRST_N = 1'b1;
        return;
      end
    end
    iStart = 1'b0;
    chk("done_time", done_t, NFR * FT + 2);
    chk("done_pulses", done_n, 1);
    chk("ra_in_range", max_ra < N, 1'b1);
    chk("end_idle_txd", oTxd, 1'b1);
    chk("end_idle_ra", oRa, 3'd0);
  endtask

  initial begin
    logic [7:0] snap [N];
    logic [7:0] init_v [N];
    init_v = '{8'hA5, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h7E, 8'h3C, 8'hC3};
    regs = init_v;

    // Reset state and quiet idle after release.
    #2 iRST_N = 1'b0;
    repeat (3) @(negedge iCLK);
    chk("rst_txd", oTxd, 1'b1);
    chk("rst_busy", oBusy, 1'b0);
    chk("rst_done", oDone, 1'b0);
    chk("rst_ra", oRa, 3'd0);
    @(posedge iCLK); #1 iRST_N = 1'b1;
    repeat (20) @(negedge iCLK);
    chk("idle_txd", oTxd, 1'b1);
    chk("idle_busy", oBusy, 1'b0);
    chk("idle_done", oDone, 1'b0);

    // Fixed pattern dump.
    build_exp(regs);
    run_dump(-1, -1, 8'h00, 8'h00, -1);

    // Start pulse mid-dump is ignored.
    run_dump(300, -1, 8'h00, 8'h00, -1);

    // Writes during frame 0: R3 change is seen later, R0 change is not.
    snap = regs;
    snap[3] = 8'h5A;
    build_exp(snap);
    run_dump(-1, 50, 8'h11, 8'h5A, -1);
    regs = init_v;

    // Reset in the middle of data bit 4 of frame 2, then a clean restart.
    regs[1] = 8'hA0;
    regs[2] = 8'h00;
    build_exp(regs);
    run_dump(-1, -1, 8'h00, 8'h00, 2 + 2 * FT + 5 * CPB + CPB / 2);
    repeat (3) @(negedge iCLK);
    chk("post_abort_idle", oBusy, 1'b0);
    run_dump(-1, -1, 8'h00, 8'h00, -1);

    // R0=0x3C, rest zero.
    for (int i = 0; i < N; i++) regs[i] = 8'h00;
    regs[0] = 8'h3C;
    build_exp(regs);
    run_dump(-1, -1, 8'h00, 8'h00, -1);

    // Random register contents.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) regs[i] = 8'($urandom);
      build_exp(regs);
      run_dump(-1, -1, 8'h00, 8'h00, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
